// File: rtl/magic_pkg.sv
// Shared definitions for the drawing canvas and the digit classifier.
// - GRID_DIM / GRID_CELLS : bitmap geometry (30x30 cells)
// - canvas_state_t        : canvas FSM states
// - cell_idx(cx, cy)      : flat bitmap bit index, cy*30+cx
package magic_pkg;

    localparam int unsigned GRID_DIM   = 30;
    localparam int unsigned GRID_CELLS = 900;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STAMP,
        S_CLEAR
    } canvas_state_t;

    function automatic logic [9:0] cell_idx(input logic [4:0] cx, input logic [4:0] cy);
        return 10'(cy) * 10'(GRID_DIM) + 10'(cx);
    endfunction

endpackage

// File: rtl/magic_coord_map.sv
// Combinational screen-pixel to grid-cell mapping.
// Ports:
//   x, y      : pen screen coordinates (10 bit)
//   cx, cy    : grid cell of the sample (valid only when in_region)
//   in_region : sample lies inside the GRID_DIM x GRID_DIM cell drawing region
module magic_coord_map
    import magic_pkg::*;
#(
    parameter int unsigned ORIGIN_X   = 80,
    parameter int unsigned ORIGIN_Y   = 0,
    parameter int unsigned CELL_SHIFT = 4
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic [4:0] cx,
    output logic [4:0] cy,
    output logic       in_region
);

    localparam logic [10:0] SPAN = 11'(GRID_DIM << CELL_SHIFT);

    // One extra bit so a sample left of / above the origin wraps to a huge unsigned
    // offset, which then fails the single upper-bound compare.
    logic [10:0] off_x;
    logic [10:0] off_y;

    assign off_x     = {1'b0, x} - 11'(ORIGIN_X);
    assign off_y     = {1'b0, y} - 11'(ORIGIN_Y);
    assign in_region = (off_x < SPAN) && (off_y < SPAN);
    assign cx        = off_x[CELL_SHIFT +: 5];
    assign cy        = off_y[CELL_SHIFT +: 5];

endmodule

// File: rtl/magic_canvas.sv
// Drawing canvas: turns pen samples into a 30x30 binary bitmap for the digit classifier.
// Stamps a square brush around each in-region sample, clears one row per cycle on request,
// and freezes all state while the classifier holds i_lock.
// Ports:
//   i_clk, i_rst_n           : clock, asynchronous active-low reset
//   i_pen_valid/o_pen_ready  : pen sample handshake, i_pen_x/i_pen_y screen coordinates
//   i_clear                  : single-cycle clear request (remembered until serviced)
//   i_lock                   : classifier scanning; bitmap and count must not change
//   o_handwrite              : bitmap, bit cy*30+cx, 1 = ink
//   o_pixel_count            : number of set bits
//   o_busy                   : stamping, clearing or a clear pending
module magic_canvas
    import magic_pkg::*;
#(
    parameter int unsigned ORIGIN_X     = 80,
    parameter int unsigned ORIGIN_Y     = 0,
    parameter int unsigned CELL_SHIFT   = 4,
    parameter int unsigned BRUSH_RADIUS = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_pen_valid,
    input  logic [9:0]            i_pen_x,
    input  logic [9:0]            i_pen_y,
    output logic                  o_pen_ready,
    input  logic                  i_clear,
    input  logic                  i_lock,
    output logic [GRID_CELLS-1:0] o_handwrite,
    output logic [9:0]            o_pixel_count,
    output logic                  o_busy
);

    localparam logic signed [5:0] BRUSH_HI = 6'(BRUSH_RADIUS);
    localparam logic signed [5:0] BRUSH_LO = -BRUSH_HI;
    localparam logic [4:0]        LAST_ROW = 5'(GRID_DIM - 1);

    canvas_state_t          state_q, state_d;
    logic [4:0]             cx_q, cx_d, cy_q, cy_d;
    logic signed [5:0]      dx_q, dx_d, dy_q, dy_d;
    logic [4:0]             row_q, row_d;
    logic                   pend_q, pend_d;
    logic [GRID_CELLS-1:0]  bitmap_q, bitmap_d;
    logic [9:0]             count_q, count_d;

    logic [4:0]        map_cx, map_cy;
    logic              map_in;
    logic              pen_ready;
    logic signed [5:0] tx, ty;
    logic              target_ok;
    logic [9:0]        target_idx;

    magic_coord_map #(
        .ORIGIN_X  (ORIGIN_X),
        .ORIGIN_Y  (ORIGIN_Y),
        .CELL_SHIFT(CELL_SHIFT)
    ) u_coord_map (
        .x        (i_pen_x),
        .y        (i_pen_y),
        .cx       (map_cx),
        .cy       (map_cy),
        .in_region(map_in)
    );

    // Ready is forced low while reset is held, even though the state already reads idle.
    assign pen_ready = i_rst_n && (state_q == S_IDLE) && !i_lock && !pend_q && !i_clear;

    // Neighbour target in signed 6-bit so -1 and 30 are both caught by the range check.
    assign tx         = $signed({1'b0, cx_q}) + dx_q;
    assign ty         = $signed({1'b0, cy_q}) + dy_q;
    assign target_ok  = !tx[5] && !ty[5] && (tx < 6'sd30) && (ty < 6'sd30);
    assign target_idx = cell_idx(tx[4:0], ty[4:0]);

    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        row_d    = row_q;
        pend_d   = pend_q | i_clear;
        bitmap_d = bitmap_q;
        count_d  = count_q;

        case (state_q)
            S_IDLE: begin
                if (pend_q && !i_lock) begin
                    state_d = S_CLEAR;
                    row_d   = '0;
                    pend_d  = i_clear;  // a fresh request this cycle re-arms
                end else if (i_pen_valid && pen_ready && map_in) begin
                    state_d = S_STAMP;
                    cx_d    = map_cx;
                    cy_d    = map_cy;
                    dx_d    = BRUSH_LO;
                    dy_d    = BRUSH_LO;
                end
            end
            S_STAMP: begin
                if (!i_lock) begin
                    if (target_ok && !bitmap_q[target_idx]) begin
                        bitmap_d[target_idx] = 1'b1;
                        count_d              = count_q + 10'd1;
                    end
                    if (dx_q == BRUSH_HI) begin
                        dx_d = BRUSH_LO;
                        if (dy_q == BRUSH_HI) begin
                            state_d = S_IDLE;
                        end else begin
                            dy_d = dy_q + 6'sd1;
                        end
                    end else begin
                        dx_d = dx_q + 6'sd1;
                    end
                end
            end
            S_CLEAR: begin
                if (!i_lock) begin
                    for (int c = 0; c < GRID_DIM; c++) begin
                        bitmap_d[cell_idx(5'(c), row_q)] = 1'b0;
                    end
                    if (row_q == LAST_ROW) begin
                        count_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        row_d = row_q + 5'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            cx_q     <= '0;
            cy_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            row_q    <= '0;
            pend_q   <= 1'b0;
            bitmap_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            row_q    <= row_d;
            pend_q   <= pend_d;
            bitmap_q <= bitmap_d;
            count_q  <= count_d;
        end
    end

    assign o_pen_ready   = pen_ready;
    assign o_handwrite   = bitmap_q;
    assign o_pixel_count = count_q;
    assign o_busy        = (state_q != S_IDLE) || pend_q;

endmodule

// File: tb/tb_magic_canvas.sv
// Self-checking bench for magic_canvas: table of pen strokes with scoreboarded expectations
// from a small reference model, plus hand-written lock / clear sequences.
module tb_magic_canvas;

    logic         clk;
    logic         rst_n;
    logic         pen_valid;
    logic [9:0]   pen_x;
    logic [9:0]   pen_y;
    logic         pen_ready;
    logic         clear;
    logic         lock;
    logic [899:0] handwrite;
    logic [9:0]   pixel_count;
    logic         busy;

    magic_canvas dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pen_valid  (pen_valid),
        .i_pen_x      (pen_x),
        .i_pen_y      (pen_y),
        .o_pen_ready  (pen_ready),
        .i_clear      (clear),
        .i_lock       (lock),
        .o_handwrite  (handwrite),
        .o_pixel_count(pixel_count),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int low;   // cycles o_pen_ready stays low after the transfer
        int cnt;   // cumulative pixel count afterwards
    } vec_t;

    typedef struct {
        int           id;
        int           low;
        int           cnt;
        logic [899:0] bm;
    } exp_t;

    vec_t         vecs[7];
    exp_t         sb[$];
    exp_t         e;
    logic [899:0] model_bm;
    int           checks = 0;
    int           errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_bm(input string name, input logic [899:0] act, input logic [899:0] exp);
        int first;
        checks++;
        if (act !== exp) begin
            errors++;
            first = -1;
            for (int i = 899; i >= 0; i--) if (act[i] !== exp[i]) first = i;
            $display("FAIL %s: bitmap has %0d ones, expected %0d; first differing bit %0d",
                     name, $countones(act), $countones(exp), first);
        end
    endtask

    // Reference brush: 3x3 cells around the sample's 16-pixel cell, clipped to the grid.
    task automatic model_stamp(input int x, input int y);
        int cx;
        int cy;
        if (x < 80 || x >= 560 || y < 0 || y >= 480) return;
        cx = (x - 80) / 16;
        cy = y / 16;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (cx + dx >= 0 && cx + dx < 30 && cy + dy >= 0 && cy + dy < 30)
                    model_bm[(cy + dy) * 30 + cx + dx] = 1'b1;
    endtask

    task automatic stroke(input int x, input int y, output int low);
        @(negedge clk);
        pen_valid = 1'b1;
        pen_x     = 10'(x);
        pen_y     = 10'(y);
        #1;
        check("ready_at_transfer", int'(pen_ready), 1);
        @(negedge clk);
        pen_valid = 1'b0;
        low       = 0;
        for (int k = 0; k < 100; k++) begin
            if (pen_ready) break;
            low++;
            @(negedge clk);
        end
    endtask

    int low;
    int n;

    initial begin
        vecs[0] = '{x: 163, y: 112, low: 9, cnt: 9};
        vecs[1] = '{x: 80,  y: 0,   low: 9, cnt: 13};
        vecs[2] = '{x: 10,  y: 200, low: 0, cnt: 13};
        vecs[3] = '{x: 163, y: 112, low: 9, cnt: 13};
        vecs[4] = '{x: 559, y: 479, low: 9, cnt: 17};
        vecs[5] = '{x: 560, y: 100, low: 0, cnt: 17};
        vecs[6] = '{x: 300, y: 479, low: 9, cnt: 23};

        rst_n     = 1'b0;
        pen_valid = 1'b0;
        pen_x     = '0;
        pen_y     = '0;
        clear     = 1'b0;
        lock      = 1'b0;
        model_bm  = '0;

        repeat (2) @(negedge clk);
        check("reset_ready", int'(pen_ready), 0);
        check("reset_count", int'(pixel_count), 0);
        check("reset_busy", int'(busy), 0);
        check_bm("reset_bitmap", handwrite, model_bm);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", int'(pen_ready), 1);

        // Table of strokes, expectations queued before driving and popped on completion.
        for (int i = 0; i < 7; i++) begin
            model_stamp(vecs[i].x, vecs[i].y);
            sb.push_back('{id: i, low: vecs[i].low, cnt: vecs[i].cnt, bm: model_bm});
            stroke(vecs[i].x, vecs[i].y, low);
            e = sb.pop_front();
            check($sformatf("vec%0d_ready_low", e.id), low, e.low);
            check($sformatf("vec%0d_count", e.id), int'(pixel_count), e.cnt);
            check_bm($sformatf("vec%0d_bitmap", e.id), handwrite, e.bm);
        end

        // Clear requested while locked: nothing moves until lock drops, then 30 row cycles.
        @(negedge clk);
        lock  = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (4) @(negedge clk);
        check("locked_clear_busy", int'(busy), 1);
        check("locked_clear_ready", int'(pen_ready), 0);
        check("locked_clear_count", int'(pixel_count), 23);
        check_bm("locked_clear_bitmap", handwrite, model_bm);
        lock = 1'b0;
        n    = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        model_bm = '0;
        check("clear_cycles", n, 30);
        check("clear_count", int'(pixel_count), 0);
        check_bm("clear_bitmap", handwrite, model_bm);
        check("ready_after_clear", int'(pen_ready), 1);

        // Lock held for 5 cycles starting at stamp cycle 3: 9 + 5 cycles of ready low.
        model_stamp(163, 112);
        @(negedge clk);
        pen_valid = 1'b1;
        pen_x     = 10'd163;
        pen_y     = 10'd112;
        #1;
        check("lockstamp_ready_at_transfer", int'(pen_ready), 1);
        low = 0;
        for (int k = 1; k < 60; k++) begin
            @(negedge clk);
            if (k == 1) pen_valid = 1'b0;
            if (k == 3) lock = 1'b1;
            if (k == 8) begin
                check("lockstamp_count_frozen", int'(pixel_count), 2);
                lock = 1'b0;
            end
            #1;
            if (pen_ready) break;
            low++;
        end
        check("lockstamp_ready_low", low, 14);
        check("lockstamp_count", int'(pixel_count), 9);
        check_bm("lockstamp_bitmap", handwrite, model_bm);

        // Clear and in-region pen in the same idle cycle: clear wins, pen not taken.
        @(negedge clk);
        clear     = 1'b1;
        pen_valid = 1'b1;
        pen_x     = 10'd163;
        pen_y     = 10'd112;
        #1;
        check("clear_vs_pen_ready", int'(pen_ready), 0);
        @(negedge clk);
        clear     = 1'b0;
        pen_valid = 1'b0;
        n         = 0;
        for (int k = 0; k < 100; k++) begin
            if (!busy) break;
            n++;
            @(negedge clk);
        end
        model_bm = '0;
        check("clear_vs_pen_busy_cycles", n, 31);
        check("clear_vs_pen_count", int'(pixel_count), 0);
        check_bm("clear_vs_pen_bitmap", handwrite, model_bm);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
